// File: rtl/flash_burst_ctrl.sv
// Register-mapped burst front end for the SPI flash navigator: moves up to DEPTH
// 32-bit words between an internal buffer and flash, with sticky status, watchdog and irq.
module flash_burst_ctrl #(
    parameter int unsigned        DEPTH   = 8,
    parameter int unsigned        ADDR_W  = 24,
    parameter logic [ADDR_W-1:0]  BASE    = 24'h500000,
    parameter int unsigned        TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ren,
    input  logic              wen,
    input  logic [7:0]        address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              irq,
    output logic              nav_enable,
    output logic              nav_read,
    output logic              nav_write,
    output logic [ADDR_W-1:0] nav_addr,
    output logic [31:0]       nav_wdata,
    input  logic              nav_ready,
    input  logic [31:0]       nav_rdata
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_CTRL   = 8'h04;
    localparam logic [7:0] A_ADDR   = 8'h08;
    localparam logic [7:0] A_LEN    = 8'h0C;
    localparam logic [7:0] A_IRQEN  = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4:0]          len_q, len_d;
    logic [1:0]          irqen_q, irqen_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                abt_q, abt_d;
    logic                abort_pend_q, abort_pend_d;
    logic                op_wr_q, op_wr_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [31:0]         data_out_q;
    logic                irq_q;
    logic [31:0]         buf_q [DEPTH];

    logic                buf_we;
    logic [IW-1:0]       buf_widx;
    logic [31:0]         buf_wdata;
    logic                in_buf;
    logic                active;
    logic [31:0]         rdata;

    assign in_buf = (address[7:6] == 2'b01) && (address[1:0] == 2'b00) &&
                    (32'(address[5:2]) < DEPTH);
    assign active = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) ||
                    (state_q == S_WAIT_DONE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        addr_d       = addr_q;
        len_d        = len_q;
        irqen_d      = irqen_q;
        done_d       = done_q;
        err_d        = err_q;
        abt_d        = abt_q;
        abort_pend_d = abort_pend_q;
        op_wr_d      = op_wr_q;
        tmo_d        = tmo_q;
        buf_we       = 1'b0;
        buf_widx     = address[IW+1:2];
        buf_wdata    = data_in;

        // Bus writes are applied first so hardware status events below take priority.
        if (wen) begin
            case (address)
                A_STATUS: begin
                    if (data_in[2]) done_d = 1'b0;
                    if (data_in[3]) err_d  = 1'b0;
                    if (data_in[4]) abt_d  = 1'b0;
                end
                A_CTRL: begin
                    if (data_in[2] && state_q != S_IDLE) abort_pend_d = 1'b1;
                end
                A_ADDR:  addr_d  = data_in[ADDR_W-1:0];
                A_LEN:   len_d   = data_in[4:0];
                A_IRQEN: irqen_d = data_in[1:0];
                default: begin
                    if (in_buf && state_q == S_IDLE) buf_we = 1'b1;
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (wen && address == A_CTRL && (data_in[0] || data_in[1])) begin
                    if ((data_in[0] && data_in[1]) || len_q == 5'd0 || 32'(len_q) > DEPTH) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d        = '0;
                        count_d      = '0;
                        done_d       = 1'b0;
                        err_d        = 1'b0;
                        abt_d        = 1'b0;
                        abort_pend_d = 1'b0;
                        op_wr_d      = data_in[1];
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!nav_ready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d        = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (nav_ready) begin
                    state_d = S_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d        = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (!op_wr_q) begin
                    buf_we    = 1'b1;
                    buf_widx  = idx_q[IW-1:0];
                    buf_wdata = nav_rdata;
                end
                count_d = count_q + 1'b1;
                idx_d   = idx_q + 1'b1;
                if (count_d == len_q || abort_pend_q) begin
                    if (abort_pend_q) abt_d = 1'b1;
                    else              done_d = 1'b1;
                    abort_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'hDEAD_BEEF;
        case (address)
            A_STATUS: rdata = {19'd0, count_q, 3'd0, abt_q, err_q, done_q,
                               state_q != S_IDLE, state_q == S_IDLE};
            A_CTRL:   rdata = '0;
            A_ADDR:   rdata = 32'(addr_q);
            A_LEN:    rdata = {27'd0, len_q};
            A_IRQEN:  rdata = {30'd0, irqen_q};
            default: begin
                if (in_buf) rdata = buf_q[address[IW+1:2]];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            irqen_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            abt_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            op_wr_q      <= 1'b0;
            tmo_q        <= '0;
            data_out_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            irqen_q      <= irqen_d;
            done_q       <= done_d;
            err_q        <= err_d;
            abt_q        <= abt_d;
            abort_pend_q <= abort_pend_d;
            op_wr_q      <= op_wr_d;
            tmo_q        <= tmo_d;
            if (ren) data_out_q <= rdata;
            irq_q        <= (done_d & irqen_d[0]) | (err_d & irqen_d[1]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else if (buf_we) begin
            buf_q[buf_widx] <= buf_wdata;
        end
    end

    // Navigator signals are decoded from state so reset or timeout drops them at once.
    assign nav_enable = active;
    assign nav_read   = active & ~op_wr_q;
    assign nav_write  = active & op_wr_q;
    assign nav_addr   = active ? (BASE + addr_q + ADDR_W'({idx_q, 2'b00})) : '0;
    assign nav_wdata  = active ? buf_q[idx_q[IW-1:0]] : '0;
    assign data_out   = data_out_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_flash_burst_ctrl.sv
// Directed self-checking bench for flash_burst_ctrl with a reactive navigator model.
module tb_flash_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        irq;
    logic        nav_enable, nav_read, nav_write;
    logic [23:0] nav_addr;
    logic [31:0] nav_wdata;
    logic        nav_ready;
    logic [31:0] nav_rdata;

    int checks = 0;
    int errors = 0;

    flash_burst_ctrl #(
        .DEPTH   (8),
        .ADDR_W  (24),
        .BASE    (24'h500000),
        .TIMEOUT (100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ren        (ren),
        .wen        (wen),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .irq        (irq),
        .nav_enable (nav_enable),
        .nav_read   (nav_read),
        .nav_write  (nav_write),
        .nav_addr   (nav_addr),
        .nav_wdata  (nav_wdata),
        .nav_ready  (nav_ready),
        .nav_rdata  (nav_rdata)
    );

    always #5 clk = ~clk;

    // Navigator model: a rising nav_enable starts a word; ready drops for busy_len cycles.
    bit          stuck = 1'b0;
    int          busy_len = 10;
    int          busy_cnt;
    logic        prev_en;
    bit          en_seen = 1'b0;
    logic [23:0] log_addr [$];
    logic [31:0] log_wdata [$];
    logic        log_wr [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nav_ready <= 1'b1;
            nav_rdata <= '0;
            busy_cnt  <= 0;
            prev_en   <= 1'b0;
        end else begin
            prev_en <= nav_enable;
            if (nav_enable) en_seen <= 1'b1;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) nav_ready <= 1'b1;
            end else if (nav_enable && !prev_en && !stuck) begin
                nav_ready <= 1'b0;
                busy_cnt  <= busy_len;
                nav_rdata <= 32'hA5A5_0000 + {8'd0, nav_addr};
                log_addr.push_back(nav_addr);
                log_wdata.push_back(nav_wdata);
                log_wr.push_back(nav_write);
            end
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; address = a; data_in = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        ren = 1'b1; address = a;
        @(negedge clk);
        ren = 1'b0;
        d = data_out;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        st = '0;
        for (int n = 0; n < 400; n++) begin
            bus_read(8'h00, st);
            if (st[0]) break;
        end
        if (!st[0]) begin
            checks++; errors++;
            $display("FAIL %s: idle wait expired, STATUS=%h required idle bit", name, st);
        end
    endtask

    task automatic clear_log();
        log_addr.delete(); log_wdata.delete(); log_wr.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({nav_enable, nav_read, nav_write, irq} !== 4'b0 || nav_addr !== 24'd0 ||
            nav_wdata !== 32'd0 || data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b rd=%b wr=%b irq=%b addr=%h wd=%h do=%h, required all 0",
                     nav_enable, nav_read, nav_write, irq, nav_addr, nav_wdata, data_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %h required 00000001", d); end
        bus_read(8'h08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", d); end
        bus_read(8'h48, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_buf2: got %h required 0", d); end
        bus_read(8'h20, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_read: got %h required deadbeef", d); end
        bus_write(8'h0C, 32'd5);
        bus_read(8'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h required 0", d); end
        bus_read(8'h0C, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL len_rw: got %h required 5", d); end
    endtask

    task automatic test_burst_write();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) bus_write(8'(8'h40 + 4 * i), 32'(i + 1));
        bus_write(8'h08, 32'h100);
        bus_write(8'h0C, 32'd4);
        clear_log();
        bus_write(8'h04, 32'h2);
        wait_idle("burst_write");
        checks++;
        if (log_addr.size() != 4) begin
            errors++; $display("FAIL wr_word_count: got %0d required 4", log_addr.size());
        end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 24'(24'h500100 + 4 * i) || log_wdata[i] !== 32'(i + 1) || log_wr[i] !== 1'b1) begin
                errors++;
                $display("FAIL wr_word%0d: addr=%h wdata=%h wr=%b required addr=%h wdata=%h wr=1",
                         i, log_addr[i], log_wdata[i], log_wr[i], 24'(24'h500100 + 4 * i), i + 1);
            end
        end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h405) begin errors++; $display("FAIL wr_status: got %h required 00000405", d); end
    endtask

    task automatic test_burst_read_irq();
        logic [31:0] d;
        logic [31:0] exp_buf [4];
        exp_buf[0] = 32'hA5F5_0000;
        exp_buf[1] = 32'hA5F5_0004;
        exp_buf[2] = 32'hA5F5_0008;
        exp_buf[3] = 32'h0000_0004;
        bus_write(8'h10, 32'h1);
        bus_write(8'h08, 32'h0);
        bus_write(8'h0C, 32'd3);
        clear_log();
        bus_write(8'h04, 32'h1);
        wait_idle("burst_read");
        for (int i = 0; i < 4; i++) begin
            bus_read(8'(8'h40 + 4 * i), d);
            checks++;
            if (d !== exp_buf[i]) begin errors++; $display("FAIL rd_buf%0d: got %h required %h", i, d, exp_buf[i]); end
        end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h305) begin errors++; $display("FAIL rd_status: got %h required 00000305", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rd_irq_set: got %b required 1", irq); end
        bus_write(8'h00, 32'h4);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rd_irq_clear: got %b required 0", irq); end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h301) begin errors++; $display("FAIL rd_status_w1c: got %h required 00000301", d); end
    endtask

    task automatic test_reject();
        logic [31:0] d;
        logic [31:0] lens [3];
        logic [31:0] ctrls [3];
        lens[0] = 32'd0; ctrls[0] = 32'h1;
        lens[1] = 32'd9; ctrls[1] = 32'h1;
        lens[2] = 32'd2; ctrls[2] = 32'h3;
        bus_write(8'h10, 32'h0);
        for (int k = 0; k < 3; k++) begin
            bus_write(8'h00, 32'h8);
            bus_write(8'h0C, lens[k]);
            en_seen = 1'b0;
            bus_write(8'h04, ctrls[k]);
            bus_read(8'h00, d);
            checks++;
            if (d[4:0] !== 5'b01001) begin
                errors++; $display("FAIL reject%0d_status: got %h required low bits 09", k, d);
            end
            repeat (5) @(negedge clk);
            checks++;
            if (en_seen !== 1'b0) begin errors++; $display("FAIL reject%0d_nav: nav_enable seen=%b required 0", k, en_seen); end
        end
        bus_write(8'h00, 32'h8);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int n;
        stuck = 1'b1;
        bus_write(8'h10, 32'h2);
        bus_write(8'h0C, 32'd1);
        bus_write(8'h04, 32'h1);
        n = 0;
        while (nav_enable && n < 300) begin n++; @(negedge clk); end
        checks++;
        if (n != 101) begin errors++; $display("FAIL tmo_cycles: enable held %0d cycles required 101", n); end
        checks++;
        if ({nav_enable, nav_read, nav_write} !== 3'b0 || nav_addr !== 24'd0) begin
            errors++; $display("FAIL tmo_nav: en=%b rd=%b wr=%b addr=%h required 0", nav_enable, nav_read, nav_write, nav_addr);
        end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL tmo_irq: got %b required 1", irq); end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL tmo_status: got %h required 00000009", d); end
        stuck = 1'b0;
        bus_write(8'h00, 32'h8);
        bus_write(8'h10, 32'h0);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int n;
        bus_write(8'h04, 32'h4);
        bus_read(8'h00, d);
        checks++;
        if (d[4:0] !== 5'b00001) begin errors++; $display("FAIL idle_abort: got %h required low bits 01", d); end
        bus_write(8'h08, 32'h10);
        bus_write(8'h0C, 32'd8);
        clear_log();
        bus_write(8'h04, 32'h2);
        n = 0;
        while (log_addr.size() < 3 && n < 500) begin n++; @(negedge clk); end
        checks++;
        if (log_addr.size() < 3) begin errors++; $display("FAIL abort_reach_word2: issued %0d words required 3", log_addr.size()); end
        repeat (3) @(negedge clk);
        bus_write(8'h04, 32'h4);
        wait_idle("abort");
        repeat (20) @(negedge clk);
        checks++;
        if (log_addr.size() != 3) begin errors++; $display("FAIL abort_words: issued %0d required 3", log_addr.size()); end
        checks++;
        if (log_addr.size() >= 3 && (log_addr[2] !== 24'h500018 || log_wdata[2] !== 32'hA5F5_0008)) begin
            errors++; $display("FAIL abort_word2: addr=%h wdata=%h required 500018 a5f50008", log_addr[2], log_wdata[2]);
        end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h311) begin errors++; $display("FAIL abort_status: got %h required 00000311", d); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        int n;
        bus_write(8'h08, 32'h0);
        bus_write(8'h0C, 32'd2);
        bus_write(8'h04, 32'h1);
        n = 0;
        while (!(nav_enable && !nav_ready) && n < 50) begin n++; @(negedge clk); end
        repeat (2) @(negedge clk);
        checks++;
        if (nav_enable !== 1'b1) begin errors++; $display("FAIL mid_reset_setup: nav_enable=%b required 1", nav_enable); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({nav_enable, nav_read, nav_write} !== 3'b0 || nav_addr !== 24'd0 || nav_wdata !== 32'd0) begin
            errors++; $display("FAIL mid_reset_nav: en=%b rd=%b wr=%b addr=%h wd=%h required 0",
                               nav_enable, nav_read, nav_write, nav_addr, nav_wdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL mid_reset_status: got %h required 00000001", d); end
        bus_read(8'h40, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_buf0: got %h required 0", d); end
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_burst_read_irq();
        test_reject();
        test_timeout();
        test_abort();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_burst_ctrl.md
Name: flash_burst_ctrl

Overview:
Register-mapped multi-word front end for the SPI flash navigator. It generalises the single-word flash controller to bursts of up to DEPTH 32-bit words through an internal word buffer, with auto-incrementing flash address, sticky done/error/abort status, a timeout watchdog and an interrupt. It sits between the CPU peripheral bus (ren/wen/address) and one flash navigator instance.

Parameters:
DEPTH, 8, buffer words (power of 2, 1..16).
ADDR_W, 24, flash address width.
BASE, 24'h500000, offset added to every flash address.
TIMEOUT, 65535, max clk cycles per navigator phase before error.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ren  in  1  register read strobe
wen  in  1  register write strobe
address  in  8  byte register address
data_in  in  32  write data
data_out  out  32  registered read data
irq  out  1  level interrupt
nav_enable  out  1  navigator flash_enable
nav_read  out  1  navigator read_enable
nav_write  out  1  navigator write_enable
nav_addr  out  ADDR_W  navigator read/write address
nav_wdata  out  32  navigator write data
nav_ready  in  1  navigator idle/ready
nav_rdata  in  32  navigator read data

Behaviour:
Reset: reset_n is asynchronous, active-low; clock is clk. Reset clears all outputs to 0 (data_out=0, irq=0, nav_*=0), all registers, status and buffer to 0, and puts the FSM in IDLE. Reset mid-burst abandons the op immediately.
Register map (byte addresses):
- 0x00 STATUS
  - Read: bit0 idle, bit1 busy, bit2 done, bit3 error, bit4 aborted, [12:8] words completed.
  - Write: 1 to bit2/3/4 clears that bit (W1C).
- 0x04 CTRL (write-only, reads 0): bit0 start read, bit1 start write, bit2 abort.
- 0x08 ADDR (R/W): [ADDR_W-1:0] burst start address.
- 0x0C LEN (R/W): [4:0] word count.
- 0x10 IRQEN (R/W): bit0 enables done, bit1 enables error.
- 0x40+4*i, i<DEPTH: buffer word i.
  - Writes are ignored while busy.
  - Reads always return current contents.
- Any other address reads 32'hDEAD_BEEF.
Bus timing:
- data_out updates on the clk edge where ren=1 and holds otherwise.
- A write takes effect on the clk edge where wen=1.
FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> NEXT -> ISSUE or IDLE.
- IDLE, start accepted:
  - Rejected with error=1 and no navigator activity if both start bits are set, LEN=0, or LEN>DEPTH.
  - Otherwise: idx=0, count=0, busy=1, done=0, error=0, aborted=0.
- ISSUE (1 cycle): drives nav_enable=1, nav_read/nav_write per op, nav_addr=(BASE+ADDR+4*idx) mod 2^ADDR_W, nav_wdata=buf[idx].
- WAIT_BUSY: hold nav_* until nav_ready=0.
- WAIT_DONE: hold until nav_ready=1.
- NEXT:
  - On read, buf[idx]<=nav_rdata.
  - count++, idx++.
  - Drop nav_enable/nav_read/nav_write for one cycle.
  - If count==LEN, or an abort is pending: go IDLE, busy=0, and set done (or aborted if the abort was pending).
  - Otherwise go ISSUE.
Timeout:
- A counter resets on entering WAIT_BUSY and WAIT_DONE.
- Reaching TIMEOUT: error=1, all nav_* to 0, busy=0, go IDLE. Words already completed remain in the buffer and in count.
Abort:
- Latched while busy; honoured only at NEXT, never mid-word.
- Abort while idle has no effect.
Start while busy is ignored (no error).
Same-cycle hardware set and W1C of a status bit: the set wins.
irq = (done & IRQEN[0]) | (error & IRQEN[1]), registered.
Per-word latency: 1 (ISSUE) + navigator busy time + 1 (NEXT).

Test Plan:
1. Buffer 0x40..0x4C loaded with 1,2,3,4; ADDR=0x100, LEN=4, CTRL=2, navigator model ready-low for 10 cycles per word -> nav_addr sequence 0x500100/104/108/10C with matching nav_wdata; then STATUS=0x0405 (done, idle, count 4).
2. LEN=3 read; model returns 0xA5A50000+addr -> buffer words 0..2 hold the values; word 3 is unchanged; with IRQEN=1, irq=1 until STATUS is written with 0x4, then irq=0.
3. LEN=0 or LEN=DEPTH+1, or CTRL=3 -> nav_enable never asserts and STATUS bit3=1 within 1 cycle.
4. Model holds nav_ready=1 forever -> error after TIMEOUT cycles, nav_enable=0; with IRQEN=2, irq=1.
5. LEN=8 write, abort issued during word 2 busy -> word 2 completes, no word 3 issue, STATUS aborted=1, count=3.
6. reset_n pulsed low during WAIT_DONE -> all nav_* outputs 0 immediately, STATUS=0x01, buffer reads 0.
